// File: rtl/cpu_sequencer_pkg.sv
// Shared codes for the CPU sequencer: state encoding and default sizing.
`timescale 1ns/1ps
package cpu_sequencer_pkg;

  // Sequencer states; encoding is visible on the state_o port
  typedef enum logic [1:0] {
    SEQ_FETCH = 2'd0,
    SEQ_EXEC  = 2'd1,
    SEQ_HALT  = 2'd2
  } seq_state_t;

  // Default sizing of the sequencer and its performance counters
  localparam int DEF_MAX_EXEC = 4;
  localparam int DEF_RET_W    = 32;
  localparam int DEF_STALL_W  = 16;

endpackage

// File: rtl/cpu_sequencer_counter.sv
// Performance counter used by the sequencer: wrapping or saturating,
// cleared by the asynchronous reset, advanced by a single enable.
`timescale 1ns/1ps
module seq_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles; a saturating counter sticks once it reaches all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !(SATURATE && (&count))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// CPU sequencer: steps each instruction through FETCH and a variable number
// of EXEC cycles, with stall/halt control and retire/stall performance counters.
`timescale 1ns/1ps
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int MAX_EXEC = DEF_MAX_EXEC,
  parameter int RET_W    = DEF_RET_W,
  parameter int STALL_W  = DEF_STALL_W,
  parameter int LEN_W    = $clog2(MAX_EXEC + 1),
  parameter int STEP_W   = $clog2(MAX_EXEC)
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               halt_i,
  input  logic               stall_i,
  input  logic [LEN_W-1:0]   exec_len_i,
  output seq_state_t         state_o,
  output logic [STEP_W-1:0]  exec_step_o,
  output logic               instr_done_o,
  output logic               halted_o,
  output logic [RET_W-1:0]   retired_o,
  output logic [STALL_W-1:0] stall_cycles_o
);

  seq_state_t        state_q;
  logic [STEP_W-1:0] step_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_raw;
  logic [LEN_W-1:0]  eff_len;
  logic              last_step;
  logic              advance;
  logic              stall_count_en;

  // Effective length: decode value at step 0, latched copy afterwards,
  // with 0 promoted to 1 and oversize values clamped to MAX_EXEC
  always_comb begin
    len_raw = (step_q == '0) ? exec_len_i : len_q;
    if (len_raw == '0) begin
      eff_len = LEN_W'(1);
    end else if (len_raw > LEN_W'(MAX_EXEC)) begin
      eff_len = LEN_W'(MAX_EXEC);
    end else begin
      eff_len = len_raw;
    end
  end

  assign last_step      = (LEN_W'(step_q) == (eff_len - 1'b1));
  assign advance        = !stall_i && !halt_i;
  assign instr_done_o   = (state_q == SEQ_EXEC) && advance && last_step;
  assign stall_count_en = stall_i && !halt_i && (state_q != SEQ_HALT);

  // Main sequencing FSM: halt wins over stall, HALT only leaves on reset
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SEQ_FETCH;
      step_q  <= '0;
      len_q   <= LEN_W'(1);
    end else if (halt_i) begin
      state_q <= SEQ_HALT;
      step_q  <= '0;
    end else if (state_q == SEQ_HALT || stall_i) begin
      state_q <= state_q;
    end else begin
      case (state_q)
        SEQ_FETCH: begin
          state_q <= SEQ_EXEC;
          step_q  <= '0;
        end
        SEQ_EXEC: begin
          if (step_q == '0) begin
            len_q <= eff_len;
          end
          if (last_step) begin
            state_q <= SEQ_FETCH;
            step_q  <= '0;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        default: begin
          state_q <= SEQ_FETCH;
          step_q  <= '0;
        end
      endcase
    end
  end

  assign state_o     = state_q;
  assign halted_o    = (state_q == SEQ_HALT);
  assign exec_step_o = (state_q == SEQ_EXEC) ? step_q : '0;

  seq_counter #(
    .WIDTH    (RET_W),
    .SATURATE (1'b0)
  ) u_retired (
    .clk   (clk),
    .rst   (reset_i),
    .inc   (instr_done_o),
    .count (retired_o)
  );

  seq_counter #(
    .WIDTH    (STALL_W),
    .SATURATE (1'b1)
  ) u_stalls (
    .clk   (clk),
    .rst   (reset_i),
    .inc   (stall_count_en),
    .count (stall_cycles_o)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with small counters so wrap and
// saturation are reachable quickly.
`timescale 1ns/1ps
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int MAX_EXEC = 4;
  localparam int RET_W    = 4;
  localparam int STALL_W  = 4;
  localparam int LEN_W    = 3;
  localparam int STEP_W   = 2;

  logic               clk;
  logic               reset_i;
  logic               halt_i;
  logic               stall_i;
  logic [LEN_W-1:0]   exec_len_i;
  seq_state_t         state_o;
  logic [STEP_W-1:0]  exec_step_o;
  logic               instr_done_o;
  logic               halted_o;
  logic [RET_W-1:0]   retired_o;
  logic [STALL_W-1:0] stall_cycles_o;

  int total = 0;
  int bad   = 0;

  cpu_sequencer #(
    .MAX_EXEC (MAX_EXEC),
    .RET_W    (RET_W),
    .STALL_W  (STALL_W)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .halt_i         (halt_i),
    .stall_i        (stall_i),
    .exec_len_i     (exec_len_i),
    .state_o        (state_o),
    .exec_step_o    (exec_step_o),
    .instr_done_o   (instr_done_o),
    .halted_o       (halted_o),
    .retired_o      (retired_o),
    .stall_cycles_o (stall_cycles_o)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic halt, input logic stall, input logic [LEN_W-1:0] len);
    halt_i     = halt;
    stall_i    = stall;
    exec_len_i = len;
  endtask

  // Advance one clock edge, then settle 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input seq_state_t st, input logic [STEP_W-1:0] step,
                            input logic done);
    checkOutput({tag, "_state"}, 32'(state_o), 32'(st));
    checkOutput({tag, "_step"}, 32'(exec_step_o), 32'(step));
    checkOutput({tag, "_done"}, 32'(instr_done_o), 32'(done));
  endtask

  initial begin
    reset_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd2);
    #2;
    // Reset values while reset is held
    checkState("rst", SEQ_FETCH, 2'd0, 1'b0);
    checkOutput("rst_retired", 32'(retired_o), 32'd0);
    checkOutput("rst_stalls", 32'(stall_cycles_o), 32'd0);
    checkOutput("rst_halted", 32'(halted_o), 32'd0);
    tick();
    checkOutput("rst_hold_state", 32'(state_o), 32'(SEQ_FETCH));
    reset_i = 1'b0;

    // Constant length 2: F,E0,E1 repeated, done every third cycle
    for (int i = 0; i < 9; i++) begin
      case (i % 3)
        0: checkState("len2_f", SEQ_FETCH, 2'd0, 1'b0);
        1: checkState("len2_e0", SEQ_EXEC, 2'd0, 1'b0);
        default: checkState("len2_e1", SEQ_EXEC, 2'd1, 1'b1);
      endcase
      tick();
    end
    checkOutput("len2_retired", 32'(retired_o), 32'd3);

    // Length 0 behaves as a single EXEC cycle
    applyStimulus(1'b0, 1'b0, 3'd0);
    tick();
    checkState("len0_e0", SEQ_EXEC, 2'd0, 1'b1);
    tick();
    checkState("len0_f", SEQ_FETCH, 2'd0, 1'b0);
    checkOutput("len0_retired", 32'(retired_o), 32'd4);

    // Length 7 clamps to 4 steps
    applyStimulus(1'b0, 1'b0, 3'd7);
    tick();
    checkState("len7_e0", SEQ_EXEC, 2'd0, 1'b0);
    tick();
    checkState("len7_e1", SEQ_EXEC, 2'd1, 1'b0);
    tick();
    checkState("len7_e2", SEQ_EXEC, 2'd2, 1'b0);
    tick();
    checkState("len7_e3", SEQ_EXEC, 2'd3, 1'b1);
    tick();
    checkState("len7_f", SEQ_FETCH, 2'd0, 1'b0);
    checkOutput("len7_retired", 32'(retired_o), 32'd5);

    // Length latched at step 0; later change to 1 is ignored
    applyStimulus(1'b0, 1'b0, 3'd3);
    tick();
    checkState("latch_e0", SEQ_EXEC, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd1);
    checkState("latch_e1", SEQ_EXEC, 2'd1, 1'b0);
    tick();
    checkState("latch_e2", SEQ_EXEC, 2'd2, 1'b1);
    tick();
    checkState("latch_f", SEQ_FETCH, 2'd0, 1'b0);
    checkOutput("latch_retired", 32'(retired_o), 32'd6);

    // Three stall cycles at E1 with length 3
    applyStimulus(1'b0, 1'b0, 3'd3);
    tick();
    tick();
    checkState("stall_pre", SEQ_EXEC, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      checkState("stall_hold", SEQ_EXEC, 2'd1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 3'd3);
    checkOutput("stall_count", 32'(stall_cycles_o), 32'd3);
    checkState("stall_post_e1", SEQ_EXEC, 2'd1, 1'b0);
    tick();
    checkState("stall_post_e2", SEQ_EXEC, 2'd2, 1'b1);
    tick();
    checkOutput("stall_retired", 32'(retired_o), 32'd7);

    // Halt together with stall at E0: HALT next edge, counters frozen
    tick();
    checkState("halt_e0", SEQ_EXEC, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd3);
    checkOutput("halt_done_low", 32'(instr_done_o), 32'd0);
    tick();
    checkState("halt_enter", SEQ_HALT, 2'd0, 1'b0);
    checkOutput("halt_flag", 32'(halted_o), 32'd1);
    checkOutput("halt_stalls", 32'(stall_cycles_o), 32'd3);
    applyStimulus(1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 10; i++) tick();
    checkState("halt_sticky", SEQ_HALT, 2'd0, 1'b0);
    checkOutput("halt_retired", 32'(retired_o), 32'd7);
    checkOutput("halt_stalls_frozen", 32'(stall_cycles_o), 32'd3);

    // Asynchronous reset out of HALT between edges
    #1 reset_i = 1'b1;
    #1;
    checkState("arst_halt", SEQ_FETCH, 2'd0, 1'b0);
    checkOutput("arst_halt_flag", 32'(halted_o), 32'd0);
    #1 reset_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0);
    tick();
    tick();
    checkOutput("arst_pre_retired", 32'(retired_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 3'd3);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 3'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd3);
    tick();
    checkState("arst_e2", SEQ_EXEC, 2'd2, 1'b1);
    checkOutput("arst_pre_stalls", 32'(stall_cycles_o), 32'd1);
    #1 reset_i = 1'b1;
    #1;
    checkState("arst_mid", SEQ_FETCH, 2'd0, 1'b0);
    checkOutput("arst_retired", 32'(retired_o), 32'd0);
    checkOutput("arst_stalls", 32'(stall_cycles_o), 32'd0);
    #1 reset_i = 1'b0;

    // Retire counter wraps after 16 with a 4-bit width
    applyStimulus(1'b0, 1'b0, 3'd0);
    tick();
    checkState("restart_e0", SEQ_EXEC, 2'd0, 1'b1);
    tick();
    for (int i = 0; i < 14; i++) begin
      tick();
      tick();
    end
    checkOutput("wrap_15", 32'(retired_o), 32'd15);
    tick();
    tick();
    checkOutput("wrap_0", 32'(retired_o), 32'd0);

    // Stall counter saturates at 15 with a 4-bit width
    applyStimulus(1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("sat_15", 32'(stall_cycles_o), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("sat_20", 32'(stall_cycles_o), 32'd15);
    checkState("sat_state", SEQ_FETCH, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_EXEC, default 4, meaning the maximum number of execute cycles per instruction (legal range 2..16).
REQ-002 The block SHALL have parameter RET_W, default 32, meaning the retired-instruction counter width.
REQ-003 The block SHALL have parameter STALL_W, default 16, meaning the stall-cycle counter width.
REQ-004 Derived widths SHALL be LEN_W = $clog2(MAX_EXEC+1) and STEP_W = $clog2(MAX_EXEC).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock, all state updates on posedge.
REQ-007 reset_i  input  1  asynchronous active-high reset.
REQ-008 halt_i  input  1  request to enter HALT.
REQ-009 stall_i  input  1  freeze sequencing this cycle.
REQ-010 exec_len_i  input  LEN_W  execute-cycle count of the current instruction, from decode.
REQ-011 state_o  output  seq_state_t  current state.
REQ-012 exec_step_o  output  STEP_W  current execute step index, 0-based.
REQ-013 instr_done_o  output  1  combinational pulse on the retiring cycle.
REQ-014 halted_o  output  1  high when state is SEQ_HALT.
REQ-015 retired_o  output  RET_W  count of retired instructions.
REQ-016 stall_cycles_o  output  STALL_W  count of stalled non-HALT cycles.

Function
REQ-017 States SHALL be SEQ_FETCH, SEQ_EXEC and SEQ_HALT.
REQ-018 halt_i=1 in any state SHALL move the block to SEQ_HALT on the next edge, with priority over stall_i.
REQ-019 SEQ_HALT SHALL be sticky until reset.
REQ-020 stall_i=1 outside SEQ_HALT SHALL hold state, step and latched length unchanged.
REQ-021 SEQ_FETCH without stall or halt SHALL go to SEQ_EXEC with step 0.
REQ-022 At step 0 the effective length SHALL be taken from exec_len_i directly.
REQ-023 At step 0 the effective length SHALL be latched on a non-stalled cycle.
REQ-024 Steps 1 and above SHALL use the latched length and ignore changes on exec_len_i.
REQ-025 An effective length of 0 SHALL be treated as 1.
REQ-026 An effective length greater than MAX_EXEC SHALL be clamped to MAX_EXEC.
REQ-027 In SEQ_EXEC, when step = len-1 and there is no stall or halt, instr_done_o SHALL be 1 and the next state SHALL be SEQ_FETCH with step 0.
REQ-028 In SEQ_EXEC otherwise without stall or halt, the step SHALL increment by 1.
REQ-029 instr_done_o SHALL be 0 whenever stall_i or halt_i is 1, or the state is not SEQ_EXEC.
REQ-030 retired_o SHALL increment by 1 on each instr_done_o and wrap modulo 2^RET_W.
REQ-031 stall_cycles_o SHALL increment on each cycle with stall_i=1, halt_i=0 and state not SEQ_HALT, and SHALL saturate at all-ones.
REQ-032 exec_step_o SHALL read 0 outside SEQ_EXEC.

Reset
REQ-033 Asserting reset_i SHALL act immediately, without waiting for clk, including mid-instruction and in SEQ_HALT.
REQ-034 Reset values SHALL be: state SEQ_FETCH, step 0, latched length 1, retired_o 0, stall_cycles_o 0, halted_o 0.
REQ-035 Under reset, instr_done_o SHALL be 0.
REQ-036 On release of reset_i, sequencing SHALL begin from SEQ_FETCH at the first clk edge.

Structure
REQ-037 seq_state_t (2-bit enum) SHALL be added to the shared codes package.
REQ-038 Defaults for MAX_EXEC, RET_W and STALL_W SHALL be constants in the codes package.
REQ-039 The two performance counters SHALL be instances of one sub-module, seq_counter, with parameters WIDTH and SATURATE, a clear on reset and an increment enable.

Verification (MAX_EXEC=4 unless stated)
REQ-040 Constant length: exec_len_i=2, no stall, 9 cycles after reset -> state sequence F,E0,E1 repeated; instr_done_o high every 3rd cycle; retired_o=3.
REQ-041 Length edge cases: exec_len_i=0 -> exactly one EXEC cycle; exec_len_i=7 -> steps 0..3 then FETCH; exec_len_i changed 3->1 at step 1 -> still retires at step 2.
REQ-042 Stall: stall_i high 3 cycles at E1 with len 3 -> exec_step_o holds at 1; stall_cycles_o +3; instr_done_o delayed 3 cycles.
REQ-043 Halt: halt_i=1 with stall_i=1 at E0 -> SEQ_HALT next edge; halted_o=1; retired_o unchanged; still HALT after 10 cycles with halt_i=0; stall_cycles_o frozen.
REQ-044 Async reset: reset_i pulsed between edges at E2 -> state_o=SEQ_FETCH and counters 0 before the next posedge.
REQ-045 Counter limits: RET_W=4, 16 retirements -> retired_o=0; STALL_W=4, 20 stall cycles -> stall_cycles_o=15.
